// File: rtl/irq_ctrl_pkg.sv
// Shared register map and field positions for the interrupt controller.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_PEND  = 2'd1,
        REG_CLAIM = 2'd2,
        REG_EOI   = 2'd3
    } reg_addr_e;

    localparam int unsigned MASK_LSB  = 0;
    localparam int unsigned EDGE_LSB  = 8;
    localparam int unsigned GIE_BIT   = 16;
    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned ID_W      = 3;
    localparam int unsigned MAX_IRQ   = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-lowest-set over eight request bits; bit 0 wins.
module irq_prio_enc (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (req[i] && !any) begin
                idx = 3'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Level/edge interrupt controller with mask, GIE, claim/EOI nesting and
// a registered interrupt request towards CP0.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 6
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic [3:2]         ADDR_I,
    input  logic               WE_I,
    input  logic [31:0]        DAT_I,
    output logic [31:0]        DAT_O,
    input  logic [NUM_IRQ-1:0] IRQ_I,
    output logic               INT_O
);

    localparam logic [MAX_IRQ-1:0] IMPL = MAX_IRQ'((9'd1 << NUM_IRQ) - 9'd1);

    reg_addr_e          addr;
    logic [MAX_IRQ-1:0] irq_q, irq_d, pend, isr, mask_r, edge_r;
    logic               gie_r, int_q;
    logic [MAX_IRQ-1:0] evt, clr, claim_oh, isr_clr, below_top, cand_req;
    logic [ID_W-1:0]    top_idx, cand_id;
    logic               top_any, cand_valid;
    logic               wr_ctrl, wr_pend, wr_claim, wr_eoi;
    logic               unused_dat;

    assign addr       = reg_addr_e'(ADDR_I);
    assign unused_dat = ^DAT_I[31:17];

    irq_prio_enc u_top (
        .req (isr),
        .idx (top_idx),
        .any (top_any)
    );

    // Only lines strictly above the highest-priority in-service line may compete.
    assign below_top = top_any ? ((8'd1 << top_idx) - 8'd1) : '1;
    assign cand_req  = pend & mask_r & {MAX_IRQ{gie_r}} & below_top;

    irq_prio_enc u_cand (
        .req (cand_req),
        .idx (cand_id),
        .any (cand_valid)
    );

    always_comb begin
        wr_ctrl  = WE_I && (addr == REG_CTRL);
        wr_pend  = WE_I && (addr == REG_PEND);
        wr_claim = WE_I && (addr == REG_CLAIM);
        wr_eoi   = WE_I && (addr == REG_EOI);
        evt      = irq_q & ~irq_d;
        claim_oh = (wr_claim && cand_valid) ? (8'd1 << cand_id) : '0;
        clr      = (wr_pend ? DAT_I[7:0] : '0) | claim_oh;
        isr_clr  = wr_eoi ? (8'd1 << DAT_I[ID_W-1:0]) : '0;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            irq_q  <= '0;
            irq_d  <= '0;
            pend   <= '0;
            isr    <= '0;
            mask_r <= '0;
            edge_r <= '0;
            gie_r  <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            irq_q <= MAX_IRQ'(IRQ_I) & IMPL;
            irq_d <= irq_q;
            // Edge bits: event ORed in after the clear, so a same-edge event wins.
            pend  <= ((edge_r & ((pend & ~clr) | evt)) | (~edge_r & irq_q)) & IMPL;
            isr   <= ((isr | claim_oh) & ~isr_clr) & IMPL;
            if (wr_ctrl) begin
                mask_r <= DAT_I[MASK_LSB +: MAX_IRQ] & IMPL;
                edge_r <= DAT_I[EDGE_LSB +: MAX_IRQ] & IMPL;
                gie_r  <= DAT_I[GIE_BIT];
            end
            int_q <= cand_valid;
        end
    end

    assign INT_O = int_q;

    always_comb begin
        DAT_O = '0;
        case (addr)
            REG_CTRL: begin
                DAT_O[MASK_LSB +: MAX_IRQ] = mask_r;
                DAT_O[EDGE_LSB +: MAX_IRQ] = edge_r;
                DAT_O[GIE_BIT]             = gie_r;
            end
            REG_PEND:  DAT_O[MAX_IRQ-1:0] = pend;
            REG_CLAIM: begin
                if (cand_valid) begin
                    DAT_O[VALID_BIT] = 1'b1;
                    DAT_O[ID_W-1:0]  = cand_id;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed table-driven bench for irq_ctrl (NUM_IRQ = 6).
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        CLK_I, RST_I, WE_I, INT_O;
    logic [3:2]  ADDR_I;
    logic [31:0] DAT_I, DAT_O;
    logic [5:0]  IRQ_I;

    irq_ctrl #(.NUM_IRQ(6)) dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .ADDR_I (ADDR_I),
        .WE_I   (WE_I),
        .DAT_I  (DAT_I),
        .DAT_O  (DAT_O),
        .IRQ_I  (IRQ_I),
        .INT_O  (INT_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] dat;
        logic [5:0]  irq;
        logic [1:0]  rd;
        logic [31:0] exp_dat;
        logic        exp_int;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    vec_t vt[$];

    function automatic vec_t mk(logic [1:0] a, logic we, logic [31:0] d, logic [5:0] irq,
                                logic [1:0] rd, logic [31:0] ed, logic ei);
        vec_t v;
        v.addr = a; v.we = we; v.dat = d; v.irq = irq;
        v.rd = rd; v.exp_dat = ed; v.exp_int = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    localparam logic [1:0] C = 2'd0, P = 2'd1, V = 2'd2, E = 2'd3;

    initial begin
        int cyc;
        RST_I = 1'b1; WE_I = 1'b0; ADDR_I = 2'd0; DAT_I = '0; IRQ_I = '0;
        repeat (3) tick();
        for (int a = 0; a < 4; a++) begin
            ADDR_I = 2'(a);
            #1;
            check($sformatf("reset DAT_O addr %0d", a), DAT_O, 32'h0);
        end
        check("reset INT_O", {31'b0, INT_O}, 32'h0);
        RST_I = 1'b0;

        // level basic
        vt.push_back(mk(C, 1, 32'h0001_0001, 6'h00, C, 32'h0001_0001, 0));
        vt.push_back(mk(C, 0, 0, 6'h01, V, 32'h0, 0));
        vt.push_back(mk(C, 0, 0, 6'h01, V, 32'h8000_0000, 0));
        vt.push_back(mk(C, 0, 0, 6'h01, V, 32'h8000_0000, 1));
        vt.push_back(mk(V, 1, 0, 6'h01, V, 32'h0, 1));
        vt.push_back(mk(C, 0, 0, 6'h01, V, 32'h0, 0));
        vt.push_back(mk(E, 1, 0, 6'h01, V, 32'h8000_0000, 0));
        vt.push_back(mk(C, 0, 0, 6'h01, V, 32'h8000_0000, 1));
        vt.push_back(mk(C, 0, 0, 6'h00, P, 32'h1, 1));
        vt.push_back(mk(C, 0, 0, 6'h00, P, 32'h0, 1));
        vt.push_back(mk(C, 0, 0, 6'h00, V, 32'h0, 0));
        // edge capture
        vt.push_back(mk(C, 1, 32'h0001_0404, 6'h00, C, 32'h0001_0404, 0));
        vt.push_back(mk(C, 0, 0, 6'h04, P, 32'h0, 0));
        vt.push_back(mk(C, 0, 0, 6'h00, P, 32'h4, 0));
        vt.push_back(mk(C, 0, 0, 6'h00, V, 32'h8000_0002, 1));
        vt.push_back(mk(V, 1, 0, 6'h00, P, 32'h0, 1));
        vt.push_back(mk(C, 0, 0, 6'h04, V, 32'h0, 0));
        vt.push_back(mk(C, 0, 0, 6'h00, P, 32'h4, 0));
        vt.push_back(mk(C, 0, 0, 6'h00, V, 32'h0, 0));
        vt.push_back(mk(E, 1, 2, 6'h00, V, 32'h8000_0002, 0));
        vt.push_back(mk(C, 0, 0, 6'h00, V, 32'h8000_0002, 1));
        vt.push_back(mk(P, 1, 32'h4, 6'h00, P, 32'h0, 1));
        vt.push_back(mk(C, 0, 0, 6'h00, V, 32'h0, 0));
        // W1C vs same-edge event
        vt.push_back(mk(C, 0, 0, 6'h04, P, 32'h0, 0));
        vt.push_back(mk(P, 1, 32'h4, 6'h00, P, 32'h4, 0));
        vt.push_back(mk(P, 1, 32'h4, 6'h00, P, 32'h0, 1));
        vt.push_back(mk(C, 0, 0, 6'h00, V, 32'h0, 0));
        // priority and nesting: lines 1,3 level, line 0 edge
        vt.push_back(mk(C, 1, 32'h0001_010B, 6'h0A, C, 32'h0001_010B, 0));
        vt.push_back(mk(C, 0, 0, 6'h0A, V, 32'h8000_0001, 0));
        vt.push_back(mk(V, 1, 0, 6'h0A, V, 32'h0, 1));
        vt.push_back(mk(C, 0, 0, 6'h0A, V, 32'h0, 0));
        vt.push_back(mk(C, 0, 0, 6'h0B, V, 32'h0, 0));
        vt.push_back(mk(C, 0, 0, 6'h0A, V, 32'h8000_0000, 0));
        vt.push_back(mk(C, 0, 0, 6'h0A, V, 32'h8000_0000, 1));
        vt.push_back(mk(V, 1, 0, 6'h0A, V, 32'h0, 1));
        vt.push_back(mk(E, 1, 0, 6'h08, V, 32'h0, 0));
        vt.push_back(mk(E, 1, 1, 6'h08, V, 32'h8000_0003, 0));
        vt.push_back(mk(C, 0, 0, 6'h08, V, 32'h8000_0003, 1));
        // GIE, stray EOI, mask, unimplemented CTRL bits
        vt.push_back(mk(C, 1, 32'h0000_010B, 6'h08, V, 32'h0, 1));
        vt.push_back(mk(C, 0, 0, 6'h08, V, 32'h0, 0));
        vt.push_back(mk(E, 1, 5, 6'h08, P, 32'h8, 0));
        vt.push_back(mk(C, 1, 32'h0001_010B, 6'h08, V, 32'h8000_0003, 0));
        vt.push_back(mk(C, 0, 0, 6'h08, V, 32'h8000_0003, 1));
        vt.push_back(mk(C, 1, 32'h0001_0103, 6'h08, V, 32'h0, 1));
        vt.push_back(mk(C, 0, 0, 6'h08, C, 32'h0001_0103, 0));
        vt.push_back(mk(C, 1, 32'hFFFF_FFFF, 6'h08, C, 32'h0001_3F3F, 0));
        vt.push_back(mk(C, 0, 0, 6'h08, P, 32'h8, 1));
        vt.push_back(mk(C, 0, 0, 6'h08, E, 32'h0, 1));

        foreach (vt[n]) begin
            ADDR_I = vt[n].addr; WE_I = vt[n].we; DAT_I = vt[n].dat; IRQ_I = vt[n].irq;
            tick();
            WE_I = 1'b0; ADDR_I = vt[n].rd;
            #1;
            check($sformatf("vec %0d DAT_O", n), DAT_O, vt[n].exp_dat);
            check($sformatf("vec %0d INT_O", n), {31'b0, INT_O}, {31'b0, vt[n].exp_int});
        end

        // claim line 3 so isr is non-empty, then reset mid-service
        ADDR_I = V; WE_I = 1'b1; DAT_I = '0;
        tick();
        WE_I = 1'b0;
        #1;
        check("claim 3 blocks vector", DAT_O, 32'h0);
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        for (int a = 0; a < 4; a++) begin
            ADDR_I = 2'(a);
            #1;
            check($sformatf("mid-service reset addr %0d", a), DAT_O, 32'h0);
        end
        check("mid-service reset INT_O", {31'b0, INT_O}, 32'h0);

        // in-service state must be gone: line 3 level serviceable again
        ADDR_I = C; WE_I = 1'b1; DAT_I = 32'h0001_000F;
        tick();
        WE_I = 1'b0; ADDR_I = V;
        cyc = 0;
        while (!INT_O && cyc < 10) begin
            tick();
            cyc++;
        end
        check("post-reset INT_O latency", 32'(cyc), 32'd2);
        check("post-reset vector", DAT_O, 32'h8000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
